// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the multi-lane windowed MAC.
//   - default widths (pixel/weight/result, lanes, window depth, accumulator)
//   - MAC_LANE slice macro: lane i of a packed lane vector of width w
//   - round_shift(): round-half-up arithmetic right shift
//   - sat_clamp():   clamp to a signed range of 'bits' bits, reporting saturation
// Arithmetic helpers work on a fixed 64-bit signed type, so they serve any
// instantiation whose accumulator fits in 64 bits.
`ifndef MAC_PKG_SV
`define MAC_PKG_SV

`define MAC_LANE(vec, i, w) vec[(i)*(w) +: (w)]

package mac_pkg;

  localparam int MAC_BIT      = 8;
  localparam int MAC_LANES    = 4;
  localparam int MAC_MAX_TAPS = 32;
  localparam int MAC_ACC_W    = 24;
  localparam int MAC_TAP_W    = 6;

  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  typedef struct packed {
    logic  sat;
    calc_t val;
  } clamp_t;

  // Adds half an LSB of the output scale before shifting (shift 0 is exact).
  function automatic calc_t round_shift(input calc_t v, input logic [4:0] sh);
    calc_t rnd;
    rnd = (sh == 5'd0) ? calc_t'(0) : (calc_t'(1) <<< (sh - 5'd1));
    return (v + rnd) >>> sh;
  endfunction

  // Clamp to [-(2^(bits-1)), 2^(bits-1)-1].
  function automatic clamp_t sat_clamp(input calc_t v, input int bits);
    clamp_t r;
    calc_t  hi;
    calc_t  lo;
    hi = (calc_t'(1) <<< (bits - 1)) - calc_t'(1);
    lo = -(calc_t'(1) <<< (bits - 1));
    r.sat = 1'b0;
    r.val = v;
    if (v > hi) begin
      r.sat = 1'b1;
      r.val = hi;
    end else if (v < lo) begin
      r.sat = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/mac_lane_tree.sv
// mac_lane_tree: combinational lane arithmetic for mac_window_engine.
//   Two independent halves so the top can register between them:
//   - picture/weight -> prod   : LANES signed BIT x BIT products (2*BIT each)
//   - prod_q         -> sum    : balanced adder tree over registered products,
//                                result sign-extended to ACC_W
// Ports:
//   picture, weight  in   LANES*BIT    lane i = [i*BIT +: BIT], signed
//   prod             out  LANES*2*BIT  lane products
//   prod_q           in   LANES*2*BIT  registered lane products
//   sum              out  ACC_W        signed sum of prod_q lanes
module mac_lane_tree
  import mac_pkg::*;
#(
  parameter int BIT   = MAC_BIT,
  parameter int LANES = MAC_LANES,
  parameter int ACC_W = MAC_ACC_W
) (
  input  logic [LANES*BIT-1:0]   picture,
  input  logic [LANES*BIT-1:0]   weight,
  output logic [LANES*2*BIT-1:0] prod,
  input  logic [LANES*2*BIT-1:0] prod_q,
  output logic [ACC_W-1:0]       sum
);

  // Leaf count padded to a power of two; padding leaves are zero.
  localparam int NP = (LANES <= 1) ? 1 : (1 << $clog2(LANES));

  always_comb begin : mult
    logic [BIT-1:0]   pa;
    logic [BIT-1:0]   wb;
    logic [2*BIT-1:0] a;
    logic [2*BIT-1:0] b;
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      pa = `MAC_LANE(picture, i, BIT);
      wb = `MAC_LANE(weight, i, BIT);
      // Sign-extend to full product width; low 2*BIT bits of the product
      // are then the exact signed result.
      a = {{BIT{pa[BIT-1]}}, pa};
      b = {{BIT{wb[BIT-1]}}, wb};
      `MAC_LANE(prod, i, 2*BIT) = a * b;
    end
  end

  // Heap-ordered tree: node k has children 2k+1 and 2k+2, leaves at NP-1..2NP-2.
  always_comb begin : tree
    logic [ACC_W-1:0] node [2*NP-1];
    logic [2*BIT-1:0] p;
    p = '0;
    for (int i = 0; i < 2*NP-1; i++) node[i] = '0;
    for (int i = 0; i < LANES; i++) begin
      p = `MAC_LANE(prod_q, i, 2*BIT);
      node[NP-1+i] = {{(ACC_W-2*BIT){p[2*BIT-1]}}, p};
    end
    for (int i = NP-2; i >= 0; i--) node[i] = node[2*i+1] + node[2*i+2];
    sum = node[0];
  end

endmodule

// File: rtl/mac_window_engine.sv
// mac_window_engine: multi-lane convolution MAC with programmable window.
//   Each accepted beat yields LANES signed products that are summed and
//   accumulated over cfg_taps beats; the window total is rounded, shifted,
//   optionally ReLU'd and saturated to BIT bits.
//   Pipeline: S1 products -> S2 lane sum -> S3 accumulate -> S4 requant/output.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cfg_taps/shift/relu window config, latched on the first beat of a window
//   flush               synchronous abort of the open window and beats in S1..S3
//   in_valid/in_ready   input beat handshake; picture/weight lanes of BIT bits
//   out_valid/out_ready result handshake; out_data signed BIT result
//   busy                window open or any stage occupied
//   sat_flag            sticky saturation indicator, cleared by rst or flush
//
// Handshake: a transfer happens on a clock edge where valid & ready are both 1.
// out_valid/out_data hold until out_ready. The whole pipeline advances only
// when the output register can move (en); in_ready is en gated by flush, so
// a stall neither drops nor duplicates beats.
module mac_window_engine
  import mac_pkg::*;
#(
  parameter int BIT      = MAC_BIT,
  parameter int LANES    = MAC_LANES,
  parameter int MAX_TAPS = MAC_MAX_TAPS,
  parameter int ACC_W    = MAC_ACC_W,
  parameter int TAP_W    = MAC_TAP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TAP_W-1:0]     cfg_taps,
  input  logic [4:0]           cfg_shift,
  input  logic                 cfg_relu,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*BIT-1:0] picture,
  input  logic [LANES*BIT-1:0] weight,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT-1:0]       out_data,
  output logic                 busy,
  output logic                 sat_flag
);

  logic en;
  logic beat;

  // window counter and latched config
  logic [TAP_W-1:0] tap_cnt;
  logic [TAP_W-1:0] taps_l;
  logic [4:0]       shift_l;
  logic             relu_l;
  logic [TAP_W-1:0] taps_req;
  logic [TAP_W-1:0] cur_taps;
  logic [4:0]       cur_shift;
  logic             cur_relu;
  logic             beat_first;
  logic             beat_last;

  // S1
  logic                   s1_valid;
  logic [LANES*2*BIT-1:0] s1_prod;
  logic                   s1_first;
  logic                   s1_last;
  logic [4:0]             s1_shift;
  logic                   s1_relu;
  // S2
  logic                   s2_valid;
  logic [ACC_W-1:0]       s2_sum;
  logic                   s2_first;
  logic                   s2_last;
  logic [4:0]             s2_shift;
  logic                   s2_relu;
  // S3
  logic                   s3_valid;
  logic [ACC_W-1:0]       acc;
  logic                   s3_last;
  logic [4:0]             s3_shift;
  logic                   s3_relu;

  logic [LANES*2*BIT-1:0] prod_c;
  logic [ACC_W-1:0]       sum_c;

  // requant
  calc_t          acc_ext;
  calc_t          shifted;
  calc_t          relu_v;
  clamp_t         q;
  logic [BIT-1:0] q_data;
  logic           s4_load;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en && !flush;
  assign beat     = in_valid && in_ready;

  assign taps_req = (cfg_taps == '0)                 ? TAP_W'(1) :
                    (cfg_taps > TAP_W'(MAX_TAPS))    ? TAP_W'(MAX_TAPS) :
                                                       cfg_taps;

  // The first beat of a window uses the live config; later beats use the copy
  // latched on that first beat.
  assign beat_first = (tap_cnt == '0);
  assign cur_taps   = beat_first ? taps_req  : taps_l;
  assign cur_shift  = beat_first ? cfg_shift : shift_l;
  assign cur_relu   = beat_first ? cfg_relu  : relu_l;
  assign beat_last  = (tap_cnt == (cur_taps - TAP_W'(1)));

  assign busy = (tap_cnt != '0) || s1_valid || s2_valid || s3_valid || out_valid;

  mac_lane_tree #(
    .BIT   (BIT),
    .LANES (LANES),
    .ACC_W (ACC_W)
  ) u_tree (
    .picture (picture),
    .weight  (weight),
    .prod    (prod_c),
    .prod_q  (s1_prod),
    .sum     (sum_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_cnt <= '0;
      taps_l  <= TAP_W'(1);
      shift_l <= '0;
      relu_l  <= 1'b0;
    end else if (flush) begin
      tap_cnt <= '0;
    end else if (beat) begin
      if (beat_first) begin
        taps_l  <= taps_req;
        shift_l <= cfg_shift;
        relu_l  <= cfg_relu;
      end
      tap_cnt <= beat_last ? '0 : tap_cnt + TAP_W'(1);
    end
  end

  // S1: lane products
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_shift <= '0;
      s1_relu  <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= beat;
      if (beat) begin
        s1_prod  <= prod_c;
        s1_first <= beat_first;
        s1_last  <= beat_last;
        s1_shift <= cur_shift;
        s1_relu  <= cur_relu;
      end
    end
  end

  // S2: lane sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_shift <= '0;
      s2_relu  <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum   <= sum_c;
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_shift <= s1_shift;
        s2_relu  <= s1_relu;
      end
    end
  end

  // S3: accumulate; the first beat of a window overwrites acc so nothing
  // from the previous window carries over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid <= 1'b0;
      acc      <= '0;
      s3_last  <= 1'b0;
      s3_shift <= '0;
      s3_relu  <= 1'b0;
    end else if (flush) begin
      s3_valid <= 1'b0;
      acc      <= '0;
    end else if (en) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        acc      <= s2_first ? s2_sum : acc + s2_sum;
        s3_last  <= s2_last;
        s3_shift <= s2_shift;
        s3_relu  <= s2_relu;
      end
    end
  end

  // Requantise the accumulator: round/shift, ReLU, then saturate.
  always_comb begin
    acc_ext = {{(CALC_W-ACC_W){acc[ACC_W-1]}}, acc};
    shifted = round_shift(acc_ext, s3_shift);
    relu_v  = (s3_relu && (shifted < 0)) ? calc_t'(0) : shifted;
    q       = sat_clamp(relu_v, BIT);
    q_data  = q.val[BIT-1:0];
  end

  // A window result enters S4 only when the closing beat sits in S3 and the
  // pipeline moves; flush drops it like any other in-flight beat.
  assign s4_load = en && s3_valid && s3_last && !flush;

  // S4: output register. When en is high the previous result is either absent
  // or being taken this cycle, so out_valid simply follows s4_load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= s4_load;
      if (s4_load) out_data <= q_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (flush) begin
      sat_flag <= 1'b0;
    end else if (s4_load && q.sat) begin
      sat_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_window_engine.sv
// Directed bench for mac_window_engine (BIT=8, LANES=4, MAX_TAPS=32).
module tb_mac_window_engine;

  localparam int BIT   = 8;
  localparam int LANES = 4;
  localparam int TAP_W = 6;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [TAP_W-1:0]     cfg_taps;
  logic [4:0]           cfg_shift;
  logic                 cfg_relu;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*BIT-1:0] picture;
  logic [LANES*BIT-1:0] weight;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT-1:0]       out_data;
  logic                 busy;
  logic                 sat_flag;

  mac_window_engine #(
    .BIT      (BIT),
    .LANES    (LANES),
    .MAX_TAPS (32),
    .ACC_W    (24),
    .TAP_W    (TAP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_taps  (cfg_taps),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .picture   (picture),
    .weight    (weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .sat_flag  (sat_flag)
  );

  int total = 0;
  int bad   = 0;

  logic [BIT-1:0] got_q[$];
  logic [BIT-1:0] exp_q[$];
  logic           model_on = 1'b0;
  int             acc_cnt  = 0;

  // Reference for a one-beat window with shift 0, no ReLU.
  function automatic logic [BIT-1:0] model1(input logic [31:0] p, input logic [31:0] w);
    int s;
    logic signed [7:0] a;
    logic signed [7:0] b;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      a = p[i*8 +: 8];
      b = w[i*8 +: 8];
      s = s + int'(a) * int'(b);
    end
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return 8'(s);
  endfunction

  function automatic logic [31:0] lanes(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // scoreboard capture: results taken by downstream, expected per accepted beat
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back(out_data);
    if (!rst && in_valid && in_ready) begin
      acc_cnt <= acc_cnt + 1;
      if (model_on) exp_q.push_back(model1(picture, weight));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_results(input string tag, input int n, input int limit);
    int c;
    c = 0;
    while (got_q.size() < n && c < limit) begin
      step();
      c++;
    end
    check(tag, got_q.size(), n);
  endtask

  int             start;
  int             k;
  logic [BIT-1:0] held;

  initial begin
    rst       = 1'b1;
    cfg_taps  = 6'd1;
    cfg_shift = 5'd0;
    cfg_relu  = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    picture   = '0;
    weight    = '0;
    held      = '0;
    repeat (2) step();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sat_flag", 32'(sat_flag), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_data", $signed(out_data), 0);
    rst = 1'b0;
    step();
    check("rst_in_ready", 32'(in_ready), 1);

    // reset asserted mid-window
    cfg_taps = 6'd3;
    picture  = lanes(1, 1, 1, 1);
    weight   = lanes(1, 1, 1, 1);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    check("mid_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 0);
    step();
    rst = 1'b0;
    step();
    check("rel_in_ready", 32'(in_ready), 1);
    check("rel_busy", 32'(busy), 0);
    check("rel_out_valid", 32'(out_valid), 0);
    check("rel_sat_flag", 32'(sat_flag), 0);
    repeat (8) step();
    check("rst_no_output", got_q.size(), 0);

    // basic window: 3 beats of 4 x (2*3) = 72, latency 4
    got_q.delete();
    cfg_taps = 6'd3;
    picture  = lanes(2, 2, 2, 2);
    weight   = lanes(3, 3, 3, 3);
    in_valid = 1'b1;
    step();
    step();
    step();
    in_valid = 1'b0;
    step();
    check("basic_lat1", 32'(out_valid), 0);
    step();
    check("basic_lat2", 32'(out_valid), 0);
    step();
    check("basic_valid", 32'(out_valid), 1);
    check("basic_data", $signed(out_data), 72);
    step();
    check("basic_taken", 32'(out_valid), 0);
    check("basic_idle", 32'(busy), 0);

    // rounding and ReLU, one-beat windows back to back: -15 -> -7, then 0
    cfg_taps  = 6'd1;
    cfg_shift = 5'd1;
    cfg_relu  = 1'b0;
    picture   = lanes(-5, 0, 0, 0);
    weight    = lanes(3, 0, 0, 0);
    in_valid  = 1'b1;
    step();
    cfg_relu = 1'b1;
    step();
    in_valid = 1'b0;
    cfg_relu = 1'b0;
    step();
    check("rnd_lat", 32'(out_valid), 0);
    step();
    check("rnd_valid", 32'(out_valid), 1);
    check("rnd_data", $signed(out_data), -7);
    step();
    check("relu_valid", 32'(out_valid), 1);
    check("relu_data", $signed(out_data), 0);
    check("relu_no_sat", 32'(sat_flag), 0);
    step();
    check("relu_taken", 32'(out_valid), 0);

    // saturation: +258064>>4 -> 127, -260096>>4 -> -128
    got_q.delete();
    cfg_taps  = 6'd4;
    cfg_shift = 5'd4;
    picture   = lanes(127, 127, 127, 127);
    weight    = lanes(127, 127, 127, 127);
    in_valid  = 1'b1;
    repeat (4) step();
    picture = lanes(-128, -128, -128, -128);
    repeat (4) step();
    in_valid = 1'b0;
    wait_results("sat_count", 2, 20);
    check("sat_pos", $signed(got_q[0]), 127);
    check("sat_neg", $signed(got_q[1]), -128);
    check("sat_flag_set", 32'(sat_flag), 1);

    // backpressure: one-beat windows, output stalled 5 cycles
    got_q.delete();
    exp_q.delete();
    cfg_taps  = 6'd1;
    cfg_shift = 5'd0;
    cfg_relu  = 1'b0;
    model_on  = 1'b1;
    start     = acc_cnt;
    for (int c = 0; c < 30; c++) begin
      k = acc_cnt - start;
      if (c == 5) held = out_data;
      if (c == 7) begin
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_hold", $signed(out_data), $signed(held));
      end
      out_ready = !(c >= 4 && c < 9);
      in_valid  = (k < 10);
      picture   = lanes(k, -k, 1, 2);
      weight    = lanes(3, 1, k, -2);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    model_on  = 1'b0;
    wait_results("bp_count", 10, 20);
    check("bp_exp_count", exp_q.size(), 10);
    check("bp_first", $signed(got_q[0]), -4);
    for (int i = 0; i < 10; i++) check($sformatf("bp_item%0d", i), $signed(got_q[i]), $signed(exp_q[i]));

    // flush: partial window dropped, next full window of 1*1 gives 4
    got_q.delete();
    cfg_taps = 6'd4;
    check("pre_flush_sat", 32'(sat_flag), 1);
    picture  = lanes(5, 0, 0, 0);
    weight   = lanes(5, 0, 0, 0);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 0);
    step();
    flush = 1'b0;
    check("flush_sat_clr", 32'(sat_flag), 0);
    check("flush_idle", 32'(busy), 0);
    picture  = lanes(1, 0, 0, 0);
    weight   = lanes(1, 0, 0, 0);
    in_valid = 1'b1;
    repeat (4) step();
    in_valid = 1'b0;
    wait_results("flush_count", 1, 20);
    repeat (6) step();
    check("flush_single", got_q.size(), 1);
    check("flush_data", $signed(got_q[0]), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
